// File: rtl/clock_mode_ctrl_if.sv
// Button-pulse and control-output bundle for clock_mode_ctrl.
//   master : drives the four button pulses and observes the control outputs
//   slave  : the mode controller itself
// Pulses: inc_short, inc_long, set, sw (1-cycle, debounced)
// Outputs: counter_enable, mux[1:0], mux_outmode, alarm_sel[ALW-1:0], time_setting_enable,
//          alarm_setting_enable, field_sel[1:0], field_inc, field_inc_fast, sw_run, sw_clear,
//          timeout_abort
interface clock_mode_ctrl_if #(
  parameter int unsigned NUM_ALARMS = 2
);
  localparam int unsigned ALW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic           inc_short;
  logic           inc_long;
  logic           set;
  logic           sw;
  logic           counter_enable;
  logic [1:0]     mux;
  logic           mux_outmode;
  logic [ALW-1:0] alarm_sel;
  logic           time_setting_enable;
  logic           alarm_setting_enable;
  logic [1:0]     field_sel;
  logic           field_inc;
  logic           field_inc_fast;
  logic           sw_run;
  logic           sw_clear;
  logic           timeout_abort;

  modport master (
    output inc_short, inc_long, set, sw,
    input  counter_enable, mux, mux_outmode, alarm_sel, time_setting_enable,
           alarm_setting_enable, field_sel, field_inc, field_inc_fast, sw_run, sw_clear,
           timeout_abort
  );

  modport slave (
    input  inc_short, inc_long, set, sw,
    output counter_enable, mux, mux_outmode, alarm_sel, time_setting_enable,
           alarm_setting_enable, field_sel, field_inc, field_inc_fast, sw_run, sw_clear,
           timeout_abort
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Mode-control FSM for the digital clock. Decodes debounced button pulses into display mux
// selection, setting enables, edited-field selection and stopwatch control. All outputs are
// registered, so a response appears the cycle after the pulse.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   bus  - clock_mode_ctrl_if.slave (button pulses in, control outputs out)
// Optional feature: define CLOCK_MODE_TIMEOUT_EN to abort a SET state after TIMEOUT_CYC idle
// cycles (pulses timeout_abort). Without it, SET states are held indefinitely.
module clock_mode_ctrl #(
  parameter int unsigned NUM_ALARMS  = 2,
  parameter int unsigned NUM_FIELDS  = 3,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic              clk,
  input logic              rst,
  clock_mode_ctrl_if.slave bus
);
  localparam int unsigned    ALW       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam logic [ALW-1:0] LastAlarm = ALW'(NUM_ALARMS - 1);
  localparam logic [1:0]     LastField = 2'(NUM_FIELDS - 1);

  typedef enum logic [2:0] {StDispTime, StDispAlarm, StDispSw, StSetTime, StSetAlarm} state_e;
  typedef enum logic [2:0] {EvNone, EvSet, EvSw, EvLong, EvShort} event_e;

  state_e         state_q, state_d;
  event_e         ev;
  logic [ALW-1:0] alarm_sel_q, alarm_sel_d;
  logic [1:0]     field_sel_q, field_sel_d;
  logic [1:0]     mux_q, mux_d;
  logic           counter_enable_q, counter_enable_d;
  logic           mux_outmode_q, mux_outmode_d;
  logic           time_om_q, time_om_d;  // display format remembered for DISP_TIME
  logic           tset_en_q, tset_en_d;
  logic           aset_en_q, aset_en_d;
  logic           field_inc_q, field_inc_d;
  logic           field_fast_q, field_fast_d;
  logic           sw_run_q, sw_run_d;
  logic           sw_clear_q, sw_clear_d;
  logic           abort_q, abort_d;
  logic           set_exit;
  logic           timed_out;

  // Only the highest-priority pulse of a cycle is acted on.
  always_comb begin
    ev = EvNone;
    if (bus.set)            ev = EvSet;
    else if (bus.sw)        ev = EvSw;
    else if (bus.inc_long)  ev = EvLong;
    else if (bus.inc_short) ev = EvShort;
  end

`ifdef CLOCK_MODE_TIMEOUT_EN
  localparam int unsigned IdleW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             in_set_q, in_set_d;

  assign in_set_q  = (state_q == StSetTime) || (state_q == StSetAlarm);
  assign in_set_d  = (state_d == StSetTime) || (state_d == StSetAlarm);
  assign timed_out = (TIMEOUT_CYC != 0) && (idle_q == IdleW'(TIMEOUT_CYC));

  // Counts idle cycles while staying in a SET state; entry, exit or any pulse restarts it.
  always_comb begin
    idle_d = '0;
    if (in_set_q && in_set_d && (ev == EvNone) && (idle_q != IdleW'(TIMEOUT_CYC))) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timed_out          = 1'b0;
`endif

  // Next-state and held-register update.
  always_comb begin
    state_d      = state_q;
    alarm_sel_d  = alarm_sel_q;
    field_sel_d  = field_sel_q;
    time_om_d    = time_om_q;
    sw_run_d     = sw_run_q;
    field_inc_d  = 1'b0;
    field_fast_d = 1'b0;
    sw_clear_d   = 1'b0;
    abort_d      = 1'b0;
    set_exit     = 1'b0;
    unique case (state_q)
      StDispTime: begin
        if (ev == EvSet) begin
          state_d     = StSetTime;
          field_sel_d = '0;
        end else if (ev == EvSw) begin
          state_d     = StDispAlarm;
          alarm_sel_d = '0;
        end else if (ev == EvShort) begin
          time_om_d = ~time_om_q;
        end
      end
      StDispAlarm: begin
        if (ev == EvSet) begin
          state_d     = StSetAlarm;
          field_sel_d = '0;
        end else if (ev == EvSw) begin
          if (alarm_sel_q == LastAlarm) state_d = StDispSw;
          else                          alarm_sel_d = alarm_sel_q + 1'b1;
        end
      end
      StDispSw: begin
        if (ev == EvSw) begin
          state_d = StDispTime;
        end else if (ev == EvLong) begin
          sw_clear_d = 1'b1;
          sw_run_d   = 1'b0;
        end else if (ev == EvShort) begin
          sw_run_d = ~sw_run_q;
        end
      end
      StSetTime, StSetAlarm: begin
        unique case (ev)
          EvSet: begin
            if (field_sel_q >= LastField) set_exit = 1'b1;
            else                          field_sel_d = field_sel_q + 1'b1;
          end
          EvSw:    set_exit     = 1'b1;
          EvLong:  field_fast_d = 1'b1;
          EvShort: field_inc_d  = 1'b1;
          default: begin
            if (timed_out) begin
              set_exit = 1'b1;
              abort_d  = 1'b1;
            end
          end
        endcase
      end
      default: state_d = StDispTime;
    endcase
    if (set_exit) begin
      state_d     = (state_q == StSetTime) ? StDispTime : StDispAlarm;
      field_sel_d = '0;
    end
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    mux_d            = 2'b00;
    counter_enable_d = 1'b1;
    mux_outmode_d    = time_om_d;
    tset_en_d        = 1'b0;
    aset_en_d        = 1'b0;
    unique case (state_d)
      StDispAlarm: begin
        mux_d         = 2'b10;
        mux_outmode_d = 1'b0;
      end
      StDispSw: begin
        mux_d         = 2'b11;
        mux_outmode_d = 1'b1;
      end
      StSetTime: begin
        mux_d            = 2'b01;
        counter_enable_d = 1'b0;
        mux_outmode_d    = (field_sel_d == 2'd2);
        tset_en_d        = 1'b1;
      end
      StSetAlarm: begin
        mux_d         = 2'b10;
        mux_outmode_d = (field_sel_d == 2'd2);
        aset_en_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StDispTime;
      alarm_sel_q      <= '0;
      field_sel_q      <= '0;
      mux_q            <= 2'b00;
      counter_enable_q <= 1'b1;
      mux_outmode_q    <= 1'b0;
      time_om_q        <= 1'b0;
      tset_en_q        <= 1'b0;
      aset_en_q        <= 1'b0;
      field_inc_q      <= 1'b0;
      field_fast_q     <= 1'b0;
      sw_run_q         <= 1'b0;
      sw_clear_q       <= 1'b0;
      abort_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      alarm_sel_q      <= alarm_sel_d;
      field_sel_q      <= field_sel_d;
      mux_q            <= mux_d;
      counter_enable_q <= counter_enable_d;
      mux_outmode_q    <= mux_outmode_d;
      time_om_q        <= time_om_d;
      tset_en_q        <= tset_en_d;
      aset_en_q        <= aset_en_d;
      field_inc_q      <= field_inc_d;
      field_fast_q     <= field_fast_d;
      sw_run_q         <= sw_run_d;
      sw_clear_q       <= sw_clear_d;
      abort_q          <= abort_d;
    end
  end

  assign bus.counter_enable       = counter_enable_q;
  assign bus.mux                  = mux_q;
  assign bus.mux_outmode          = mux_outmode_q;
  assign bus.alarm_sel            = alarm_sel_q;
  assign bus.time_setting_enable  = tset_en_q;
  assign bus.alarm_setting_enable = aset_en_q;
  assign bus.field_sel            = field_sel_q;
  assign bus.field_inc            = field_inc_q;
  assign bus.field_inc_fast       = field_fast_q;
  assign bus.sw_run               = sw_run_q;
  assign bus.sw_clear             = sw_clear_q;
  assign bus.timeout_abort        = abort_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: directed scenarios followed by random button
// traffic, every cycle compared against a behavioural model of the clock's modes.
module tb_clock_mode_ctrl;
  localparam int unsigned NumAlarms  = 2;
  localparam int unsigned NumFields  = 3;
  localparam int unsigned TimeoutCyc = 8;
`ifdef CLOCK_MODE_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  localparam int MTime = 0, MAlarm = 1, MSw = 2, MSetTime = 3, MSetAlarm = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  clock_mode_ctrl_if #(.NUM_ALARMS(NumAlarms)) bus ();

  clock_mode_ctrl #(
    .NUM_ALARMS (NumAlarms),
    .NUM_FIELDS (NumFields),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model state: current mode, selections and the pulses expected on this cycle.
  int m_mode, m_sel, m_field, m_idle;
  bit m_run, m_tom, e_inc, e_fast, e_clr, e_abort;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = MTime; m_sel = 0; m_field = 0; m_idle = 0;
    m_run = 0; m_tom = 0; e_inc = 0; e_fast = 0; e_clr = 0; e_abort = 0;
  endfunction

  function automatic void model_step(bit s_short, bit s_long, bit s_set, bit s_sw);
    bit any, was_set, leave;
    any     = s_short | s_long | s_set | s_sw;
    was_set = (m_mode == MSetTime) || (m_mode == MSetAlarm);
    leave   = 0;
    e_inc = 0; e_fast = 0; e_clr = 0; e_abort = 0;
    if (was_set && !any && ToEn && TimeoutCyc > 0 && m_idle >= TimeoutCyc) begin
      leave = 1; e_abort = 1;
    end else if (s_set) begin
      if (m_mode == MTime)       begin m_mode = MSetTime;  m_field = 0; end
      else if (m_mode == MAlarm) begin m_mode = MSetAlarm; m_field = 0; end
      else if (was_set) begin
        if (m_field == NumFields - 1) leave = 1;
        else m_field++;
      end
    end else if (s_sw) begin
      if (m_mode == MTime) begin m_mode = MAlarm; m_sel = 0; end
      else if (m_mode == MAlarm) begin
        if (m_sel == NumAlarms - 1) m_mode = MSw;
        else m_sel++;
      end
      else if (m_mode == MSw) m_mode = MTime;
      else leave = 1;
    end else if (s_long) begin
      if (m_mode == MSw) begin e_clr = 1; m_run = 0; end
      else if (was_set) e_fast = 1;
    end else if (s_short) begin
      if (m_mode == MTime) m_tom = !m_tom;
      else if (m_mode == MSw) m_run = !m_run;
      else if (was_set) e_inc = 1;
    end
    if (leave) begin
      m_mode  = (m_mode == MSetTime) ? MTime : MAlarm;
      m_field = 0;
    end
    if (was_set && !leave && !any) m_idle++;
    else m_idle = 0;
  endfunction

  task automatic check_all();
    int exp_mux, exp_om;
    case (m_mode)
      MTime:    begin exp_mux = 0; exp_om = int'(m_tom); end
      MAlarm:   begin exp_mux = 2; exp_om = 0; end
      MSw:      begin exp_mux = 3; exp_om = 1; end
      MSetTime: begin exp_mux = 1; exp_om = int'(m_field == 2); end
      default:  begin exp_mux = 2; exp_om = int'(m_field == 2); end
    endcase
    chk("mux", 32'(bus.mux), 32'(exp_mux));
    chk("counter_enable", 32'(bus.counter_enable), 32'(m_mode != MSetTime));
    chk("mux_outmode", 32'(bus.mux_outmode), 32'(exp_om));
    chk("alarm_sel", 32'(bus.alarm_sel), 32'(m_sel));
    chk("time_setting_enable", 32'(bus.time_setting_enable), 32'(m_mode == MSetTime));
    chk("alarm_setting_enable", 32'(bus.alarm_setting_enable), 32'(m_mode == MSetAlarm));
    chk("field_sel", 32'(bus.field_sel), 32'(m_field));
    chk("field_inc", 32'(bus.field_inc), 32'(e_inc));
    chk("field_inc_fast", 32'(bus.field_inc_fast), 32'(e_fast));
    chk("sw_run", 32'(bus.sw_run), 32'(m_run));
    chk("sw_clear", 32'(bus.sw_clear), 32'(e_clr));
    chk("timeout_abort", 32'(bus.timeout_abort), 32'(e_abort));
  endtask

  task automatic step(input bit s_short, input bit s_long, input bit s_set, input bit s_sw);
    bus.inc_short = s_short; bus.inc_long = s_long; bus.set = s_set; bus.sw = s_sw;
    @(posedge clk);
    #1;
    bus.inc_short = 0; bus.inc_long = 0; bus.set = 0; bus.sw = 0;
    model_step(s_short, s_long, s_set, s_sw);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    bus.inc_short = 0; bus.inc_long = 0; bus.set = 0; bus.sw = 0;
    model_reset();
    @(posedge clk);
    #1;

    // 1: reset, then sw cycles through the display modes
    do_reset();
    chk("t1_reset_mux", 32'(bus.mux), 32'd0);
    step(0, 0, 0, 1); chk("t1_alarm0_mux", 32'(bus.mux), 32'd2);
    step(0, 0, 0, 1); chk("t1_alarm1_sel", 32'(bus.alarm_sel), 32'd1);
    step(0, 0, 0, 1); chk("t1_sw_mux", 32'(bus.mux), 32'd3);
    step(0, 0, 0, 1); chk("t1_time_mux", 32'(bus.mux), 32'd0);

    // 2: time setting walk through all fields
    step(0, 0, 1, 0); chk("t2_counter_en", 32'(bus.counter_enable), 32'd0);
    step(1, 0, 0, 0); chk("t2_field_inc", 32'(bus.field_inc), 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0); chk("t2_outmode", 32'(bus.mux_outmode), 32'd1);
    step(0, 0, 1, 0); chk("t2_exit_field", 32'(bus.field_sel), 32'd0);

    // 3: set and sw together, set wins
    do_reset();
    step(0, 0, 1, 1); chk("t3_mux", 32'(bus.mux), 32'd1);
    chk("t3_alarm_sel", 32'(bus.alarm_sel), 32'd0);

    // 4: idle timeout out of SET_ALARM, then restart of the idle count
    do_reset();
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 1, 0);
    idle(8);
    step(0, 0, 0, 0); chk("t4_abort", 32'(bus.timeout_abort), 32'(ToEn));
    chk("t4_alarm_sel", 32'(bus.alarm_sel), 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    idle(6);
    step(1, 0, 0, 0);
    idle(8); chk("t4_no_early_abort", 32'(bus.timeout_abort), 32'd0);
    step(0, 0, 0, 0); chk("t4_abort2", 32'(bus.timeout_abort), 32'(ToEn));

    // 5: stopwatch run persists, clear pulse stops it
    do_reset();
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(1, 0, 0, 0); chk("t5_run", 32'(bus.sw_run), 32'd1);
    step(0, 0, 0, 1); chk("t5_run_kept", 32'(bus.sw_run), 32'd1);
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(0, 1, 0, 0); chk("t5_clear", 32'(bus.sw_clear), 32'd1);
    step(0, 0, 0, 0);

    // 6: reset during an edit
    do_reset();
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    do_reset(); chk("t6_mux", 32'(bus.mux), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      else step($urandom_range(5) == 0, $urandom_range(7) == 0,
                $urandom_range(6) == 0, $urandom_range(7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
